// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter types and bus width defaults.
// Imported by wb_rr_pick and wb_arbiter.
package wb_pkg;

   localparam int WB_DW = 32;
   localparam int WB_AW = 32;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: scans last+1, last+2, ... modulo NM
// and returns the first requester as one-hot, index and valid.
module wb_rr_pick #(
   parameter int NM = 3,
   parameter int LW = 2
) (
   input  logic [NM-1:0] req,
   input  logic [LW-1:0] last,
   output logic [NM-1:0] win_oh,
   output logic [LW-1:0] win_idx,
   output logic          valid
);

   // first requester after the previous winner wins
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      valid   = 1'b0;
      for (int i = 1; i <= NM; i++) begin
         if (!valid && req[(int'(last) + i) % NM]) begin
            valid = 1'b1;
            win_idx = LW'((int'(last) + i) % NM);
            win_oh[(int'(last) + i) % NM] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one master port among NM masters.
// Optional bus timeout compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DW        = WB_DW,
   parameter int AW        = WB_AW,
   parameter int NM        = 3,
   parameter int TO_CYCLES = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NM-1:0]        i_wbm_cyc,
   input  logic [NM-1:0]        i_wbm_stb,
   input  logic [NM-1:0]        i_wbm_we,
   input  logic [NM*AW-1:0]     i_wbm_adr,
   input  logic [NM*DW-1:0]     i_wbm_dat,
   input  logic [NM*DW/8-1:0]   i_wbm_sel,
   output logic [DW-1:0]        o_wbm_dat,
   output logic [NM-1:0]        o_wbm_ack,
   output logic [NM-1:0]        o_wbm_err,
   output logic                 o_wbs_cyc,
   output logic                 o_wbs_stb,
   output logic                 o_wbs_we,
   output logic [AW-1:0]        o_wbs_adr,
   output logic [DW-1:0]        o_wbs_dat,
   output logic [DW/8-1:0]      o_wbs_sel,
   input  logic [DW-1:0]        i_wbs_dat,
   input  logic                 i_wbs_ack,
   output logic [NM-1:0]        o_grant
);

   localparam int LW = (NM > 1) ? $clog2(NM) : 1;
   localparam int SW = DW / 8;

   arb_state_t    state, state_nx;
   logic [NM-1:0] grant, grant_nx;
   logic [LW-1:0] last, last_nx;
   logic [NM-1:0] req;
   logic [NM-1:0] pick_oh;
   logic [LW-1:0] pick_idx;
   logic          pick_vld;
   logic          cyc_g, stb_g, we_g;
   logic [AW-1:0] adr_g;
   logic [DW-1:0] dat_g;
   logic [SW-1:0] sel_g;
   logic          stb_raw;
   logic          to_hit;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYCLES + 1);
   logic [CW-1:0] cnt, cnt_nx;
   logic [NM-1:0] blocked, blocked_nx;

   assign req       = i_wbm_cyc & ~blocked;
   assign to_hit    = (state == ARB_BUSY) && stb_raw && !i_wbs_ack
                      && (cnt == CW'(TO_CYCLES - 1));
   assign o_wbm_err = to_hit ? grant : '0;
`else
   assign req       = i_wbm_cyc;
   assign to_hit    = 1'b0;
   assign o_wbm_err = '0;
`endif

   wb_rr_pick #(
      .NM(NM),
      .LW(LW)
   ) u_pick (
      .req    (req),
      .last   (last),
      .win_oh (pick_oh),
      .win_idx(pick_idx),
      .valid  (pick_vld)
   );

   // arbitration state registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ARB_IDLE;
         grant <= '0;
         last  <= LW'(NM - 1);
`ifdef WB_ARB_TIMEOUT_EN
         cnt     <= '0;
         blocked <= '0;
`endif
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         last  <= last_nx;
`ifdef WB_ARB_TIMEOUT_EN
         cnt     <= cnt_nx;
         blocked <= blocked_nx;
`endif
      end
   end

   // next-state: grant on request in IDLE, release on CYC drop or timeout
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      last_nx  = last;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_nx     = cnt;
      blocked_nx = blocked & i_wbm_cyc;
`endif
      unique case (state)
         ARB_IDLE: begin
            if (pick_vld) begin
               state_nx = ARB_BUSY;
               grant_nx = pick_oh;
               last_nx  = pick_idx;
`ifdef WB_ARB_TIMEOUT_EN
               cnt_nx = '0;
`endif
            end
         end
         ARB_BUSY: begin
            if (to_hit) begin
               state_nx = ARB_IDLE;
               grant_nx = '0;
`ifdef WB_ARB_TIMEOUT_EN
               cnt_nx     = '0;
               blocked_nx = blocked_nx | grant;
`endif
            end else if (!cyc_g) begin
               state_nx = ARB_IDLE;
               grant_nx = '0;
            end
`ifdef WB_ARB_TIMEOUT_EN
            else if (i_wbs_ack) begin
               cnt_nx = '0;
            end else if (stb_raw) begin
               cnt_nx = cnt + 1'b1;
            end
`endif
         end
         default: begin
            state_nx = ARB_IDLE;
            grant_nx = '0;
         end
      endcase
   end

   // request mux from the granted master; zero when nobody holds the grant
   always_comb begin
      cyc_g = 1'b0;
      stb_g = 1'b0;
      we_g  = 1'b0;
      adr_g = '0;
      dat_g = '0;
      sel_g = '0;
      for (int m = 0; m < NM; m++) begin
         if (grant[m] && state == ARB_BUSY) begin
            cyc_g = cyc_g | i_wbm_cyc[m];
            stb_g = stb_g | i_wbm_stb[m];
            we_g  = we_g  | i_wbm_we[m];
            adr_g = adr_g | i_wbm_adr[m*AW +: AW];
            dat_g = dat_g | i_wbm_dat[m*DW +: DW];
            sel_g = sel_g | i_wbm_sel[m*SW +: SW];
         end
      end
   end

   assign stb_raw   = stb_g & cyc_g;
   assign o_wbs_cyc = cyc_g;
   assign o_wbs_stb = stb_raw & ~to_hit;
   assign o_wbs_we  = we_g;
   assign o_wbs_adr = adr_g;
   assign o_wbs_dat = dat_g;
   assign o_wbs_sel = sel_g;
   assign o_wbm_ack = grant & {NM{i_wbs_ack & o_wbs_stb}};
   assign o_wbm_dat = i_wbs_dat;
   assign o_grant   = grant;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (NM=3, DW=AW=32).
// Timeout scenario runs when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NM = 3;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic [NM-1:0]     i_wbm_cyc;
   logic [NM-1:0]     i_wbm_stb;
   logic [NM-1:0]     i_wbm_we;
   logic [NM*AW-1:0]  i_wbm_adr;
   logic [NM*DW-1:0]  i_wbm_dat;
   logic [NM*4-1:0]   i_wbm_sel;
   logic [DW-1:0]     o_wbm_dat;
   logic [NM-1:0]     o_wbm_ack;
   logic [NM-1:0]     o_wbm_err;
   logic              o_wbs_cyc;
   logic              o_wbs_stb;
   logic              o_wbs_we;
   logic [AW-1:0]     o_wbs_adr;
   logic [DW-1:0]     o_wbs_dat;
   logic [3:0]        o_wbs_sel;
   logic [DW-1:0]     i_wbs_dat;
   logic              i_wbs_ack;
   logic [NM-1:0]     o_grant;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   wb_arbiter #(
      .DW(DW),
      .AW(AW),
      .NM(NM),
`ifdef WB_ARB_TIMEOUT_EN
      .TO_CYCLES(8)
`else
      .TO_CYCLES(255)
`endif
   ) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_wbm_cyc(i_wbm_cyc),
      .i_wbm_stb(i_wbm_stb),
      .i_wbm_we (i_wbm_we),
      .i_wbm_adr(i_wbm_adr),
      .i_wbm_dat(i_wbm_dat),
      .i_wbm_sel(i_wbm_sel),
      .o_wbm_dat(o_wbm_dat),
      .o_wbm_ack(o_wbm_ack),
      .o_wbm_err(o_wbm_err),
      .o_wbs_cyc(o_wbs_cyc),
      .o_wbs_stb(o_wbs_stb),
      .o_wbs_we (o_wbs_we),
      .o_wbs_adr(o_wbs_adr),
      .o_wbs_dat(o_wbs_dat),
      .o_wbs_sel(o_wbs_sel),
      .i_wbs_dat(i_wbs_dat),
      .i_wbs_ack(i_wbs_ack),
      .o_grant  (o_grant)
   );

   task automatic idle_inputs();
      i_wbm_cyc = '0;
      i_wbm_stb = '0;
      i_wbm_we  = '0;
      i_wbm_adr = '0;
      i_wbm_dat = '0;
      i_wbm_sel = '0;
      i_wbs_dat = '0;
      i_wbs_ack = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      idle_inputs();
      i_rst_n = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [127:0] obs;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(posedge i_clk);
         #1;
         obs = {o_wbs_cyc, o_wbs_stb, o_wbs_we, o_wbs_adr, o_wbs_dat,
                o_wbs_sel, o_wbm_ack, o_wbm_err, o_grant};
         total++;
         if (obs !== '0) begin
            bad++;
            $display("FAIL reset_idle cyc%0d got=%h want=0", c, obs);
         end
      end
   endtask

   task automatic test_single();
      @(negedge i_clk);
      i_wbm_cyc[1] = 1'b1;
      i_wbm_stb[1] = 1'b1;
      i_wbm_adr[AW +: AW] = 32'h2000_0010;
      i_wbm_sel[4 +: 4] = 4'hF;
      @(posedge i_clk);
      #1;
      total++;
      if (o_wbs_stb !== 1'b1 || o_grant !== 3'b010) begin
         bad++;
         $display("FAIL single_grant stb=%b grant=%b want 1/010",
                  o_wbs_stb, o_grant);
      end
      total++;
      if (o_wbs_adr !== 32'h2000_0010 || o_wbs_we !== 1'b0
          || o_wbs_sel !== 4'hF) begin
         bad++;
         $display("FAIL single_mux adr=%h we=%b sel=%h want 20000010/0/f",
                  o_wbs_adr, o_wbs_we, o_wbs_sel);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge i_clk);
         #1;
         total++;
         if (o_wbm_ack !== 3'b000) begin
            bad++;
            $display("FAIL single_noack got=%b want=000", o_wbm_ack);
         end
      end
      @(negedge i_clk);
      i_wbs_ack = 1'b1;
      i_wbs_dat = 32'hDEAD_BEEF;
      #1;
      total++;
      if (o_wbm_ack !== 3'b010 || o_wbm_dat !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL single_ack ack=%b dat=%h want 010/deadbeef",
                  o_wbm_ack, o_wbm_dat);
      end
      @(negedge i_clk);
      i_wbs_ack = 1'b0;
      i_wbm_cyc[1] = 1'b0;
      i_wbm_stb[1] = 1'b0;
      @(posedge i_clk);
      #1;
      total++;
      if (o_grant !== 3'b000 || o_wbs_cyc !== 1'b0 || o_wbs_adr !== '0) begin
         bad++;
         $display("FAIL single_release grant=%b cyc=%b adr=%h want 0",
                  o_grant, o_wbs_cyc, o_wbs_adr);
      end
   endtask

   task automatic test_round_robin();
      logic [NM-1:0] exp_g [4];
      int w;
      exp_g[0] = 3'b001;
      exp_g[1] = 3'b010;
      exp_g[2] = 3'b100;
      exp_g[3] = 3'b001;
      do_reset();
      @(negedge i_clk);
      i_wbm_cyc = 3'b111;
      i_wbm_stb = 3'b111;
      i_wbm_we  = 3'b111;
      for (int m = 0; m < NM; m++) begin
         i_wbm_adr[m*AW +: AW] = 32'h100 * (m + 1);
         i_wbm_dat[m*DW +: DW] = 32'hA0 + m;
      end
      for (int t = 0; t < 4; t++) begin
         @(posedge i_clk);
         #1;
         w = (t == 3) ? 0 : t;
         total++;
         if (o_grant !== exp_g[t] || o_wbs_dat !== 32'hA0 + w
             || o_wbs_we !== 1'b1) begin
            bad++;
            $display("FAIL rr_grant%0d grant=%b dat=%h want %b/%h",
                     t, o_grant, o_wbs_dat, exp_g[t], 32'hA0 + w);
         end
         @(negedge i_clk);
         i_wbs_ack = 1'b1;
         #1;
         total++;
         if (o_wbm_ack !== exp_g[t]) begin
            bad++;
            $display("FAIL rr_ack%0d got=%b want=%b", t, o_wbm_ack, exp_g[t]);
         end
         @(negedge i_clk);
         i_wbs_ack = 1'b0;
         i_wbm_cyc[w] = 1'b0;
         i_wbm_stb[w] = 1'b0;
         @(posedge i_clk);
         #1;
         total++;
         if (o_grant !== 3'b000 || o_wbs_stb !== 1'b0) begin
            bad++;
            $display("FAIL rr_idle%0d grant=%b stb=%b want 000/0",
                     t, o_grant, o_wbs_stb);
         end
         @(negedge i_clk);
         i_wbm_cyc[w] = 1'b1;
         i_wbm_stb[w] = 1'b1;
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      do_reset();
      @(negedge i_clk);
      i_wbm_cyc = 3'b101;
      i_wbm_stb = 3'b101;
      i_wbm_adr[0 +: AW] = 32'h0000_0400;
      i_wbm_adr[2*AW +: AW] = 32'h0000_0800;
      for (int r = 0; r < 4; r++) begin
         @(negedge i_clk);
         i_wbs_ack = 1'b1;
         i_wbs_dat = 32'h5000 + r;
         i_wbm_adr[0 +: AW] = 32'h0000_0400 + 4 * r;
         #1;
         total++;
         if (o_grant !== 3'b001 || o_wbm_ack !== 3'b001
             || o_wbs_adr !== 32'h0000_0400 + 4 * r) begin
            bad++;
            $display("FAIL b2b_read%0d grant=%b ack=%b adr=%h",
                     r, o_grant, o_wbm_ack, o_wbs_adr);
         end
         @(negedge i_clk);
         i_wbs_ack = 1'b0;
      end
      i_wbm_cyc[0] = 1'b0;
      i_wbm_stb[0] = 1'b0;
      @(posedge i_clk);
      #1;
      total++;
      if (o_grant !== 3'b000) begin
         bad++;
         $display("FAIL b2b_gap grant=%b want=000", o_grant);
      end
      @(posedge i_clk);
      #1;
      total++;
      if (o_grant !== 3'b100 || o_wbs_adr !== 32'h0000_0800) begin
         bad++;
         $display("FAIL b2b_next grant=%b adr=%h want 100/00000800",
                  o_grant, o_wbs_adr);
      end
      @(negedge i_clk);
      idle_inputs();
      @(posedge i_clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge i_clk);
      i_wbm_cyc[1] = 1'b1;
      i_wbm_stb[1] = 1'b1;
      @(posedge i_clk);
      #1;
      total++;
      if (o_grant !== 3'b010 || o_wbs_stb !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_pre grant=%b stb=%b want 010/1",
                  o_grant, o_wbs_stb);
      end
      #2;
      i_rst_n = 1'b0;
      #1;
      total++;
      if (o_wbs_stb !== 1'b0 || o_grant !== 3'b000) begin
         bad++;
         $display("FAIL rstmid_async stb=%b grant=%b want 0/000",
                  o_wbs_stb, o_grant);
      end
      i_wbm_cyc = 3'b011;
      i_wbm_stb = 3'b011;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      total++;
      if (o_grant !== 3'b001) begin
         bad++;
         $display("FAIL rstmid_first grant=%b want=001", o_grant);
      end
      @(negedge i_clk);
      idle_inputs();
      @(posedge i_clk);
   endtask

`ifdef WB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      @(negedge i_clk);
      i_wbm_cyc = 3'b011;
      i_wbm_stb = 3'b011;
      for (int c = 1; c <= 8; c++) begin
         @(posedge i_clk);
         #1;
         total++;
         if (c < 8 && (o_wbm_err !== 3'b000 || o_wbs_stb !== 1'b1)) begin
            bad++;
            $display("FAIL to_stall%0d err=%b stb=%b", c, o_wbm_err, o_wbs_stb);
         end else if (c == 8 && (o_wbm_err !== 3'b001 || o_wbs_stb !== 1'b0)) begin
            bad++;
            $display("FAIL to_fire err=%b stb=%b want 001/0",
                     o_wbm_err, o_wbs_stb);
         end
      end
      @(posedge i_clk);
      #1;
      total++;
      if (o_grant !== 3'b000 || o_wbm_err !== 3'b000) begin
         bad++;
         $display("FAIL to_release grant=%b err=%b", o_grant, o_wbm_err);
      end
      @(posedge i_clk);
      #1;
      total++;
      if (o_grant !== 3'b010) begin
         bad++;
         $display("FAIL to_next grant=%b want=010", o_grant);
      end
      @(negedge i_clk);
      idle_inputs();
      @(posedge i_clk);
   endtask
`endif

   initial begin
      idle_inputs();
      i_rst_n = 1'b0;
      #1;
      total++;
      if (o_grant !== 3'b000 || o_wbs_stb !== 1'b0) begin
         bad++;
         $display("FAIL in_reset grant=%b stb=%b want 0", o_grant, o_wbs_stb);
      end
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back();
      test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
